// File: rtl/uart_parity_checker.sv
// Serial frame assembler and parity checker for an oversampled UART receiver.
// Collects DATA_WIDTH LSB-first bits, optionally checks a parity bit, and keeps a saturating error count.
module uart_parity_checker #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     clk_based_on_prescale,
  input  logic                     reset,
  input  logic                     parity_check_enable,
  input  logic                     sample_valid,
  input  logic                     sampled_data,
  input  logic [2:0]               parity_mode,
  input  logic                     clear_count,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     computed_parity,
  output logic                     parity_done,
  output logic                     parity_error,
  output logic [ERR_CNT_WIDTH-1:0] error_count
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  localparam logic [2:0] MODE_NONE  = 3'd0;
  localparam logic [2:0] MODE_EVEN  = 3'd1;
  localparam logic [2:0] MODE_ODD   = 3'd2;
  localparam logic [2:0] MODE_MARK  = 3'd3;
  localparam logic [2:0] MODE_SPACE = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    acc;
  logic [DATA_WIDTH-1:0]   shreg;
  logic [2:0]              mode_q;
  logic                    exp_bit;

  logic                    acc_c;
  logic                    exp_c;
  logic                    last_c;
  logic                    err_c;

  // Expected parity bit from the accumulator including the bit being accepted now
  always_comb begin
    acc_c  = acc ^ sampled_data;
    last_c = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    err_c  = sampled_data ^ exp_bit;
    exp_c  = 1'b0;
    case (mode_q)
      MODE_EVEN: exp_c = acc_c;
      MODE_ODD:  exp_c = ~acc_c;
      MODE_MARK: exp_c = 1'b1;
      default:   exp_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk_based_on_prescale or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      acc             <= 1'b0;
      shreg           <= '0;
      mode_q          <= MODE_NONE;
      exp_bit         <= 1'b0;
      data_out        <= '0;
      computed_parity <= 1'b0;
      parity_done     <= 1'b0;
      parity_error    <= 1'b0;
      error_count     <= '0;
    end else begin
      parity_done  <= 1'b0;
      parity_error <= 1'b0;
      if (clear_count) begin
        error_count <= '0;
      end

      case (state)
        IDLE: begin
          if (parity_check_enable && sample_valid) begin
            // Reserved encodings are folded into "none" once, at frame start
            mode_q   <= (parity_mode > MODE_SPACE) ? MODE_NONE : parity_mode;
            shreg[0] <= sampled_data;
            acc      <= sampled_data;
            bit_cnt  <= CNT_W'(1);
            state    <= DATA;
          end
        end

        DATA: begin
          if (!parity_check_enable) begin
            state   <= IDLE;
            bit_cnt <= '0;
            acc     <= 1'b0;
          end else if (sample_valid) begin
            shreg[bit_cnt] <= sampled_data;
            acc            <= acc_c;
            bit_cnt        <= bit_cnt + CNT_W'(1);
            if (last_c) begin
              if (mode_q == MODE_NONE) begin
                data_out        <= {sampled_data, shreg[DATA_WIDTH-2:0]};
                computed_parity <= 1'b0;
                parity_done     <= 1'b1;
                state           <= IDLE;
                bit_cnt         <= '0;
                acc             <= 1'b0;
              end else begin
                exp_bit <= exp_c;
                state   <= PARITY;
              end
            end
          end
        end

        PARITY: begin
          if (!parity_check_enable) begin
            state   <= IDLE;
            bit_cnt <= '0;
            acc     <= 1'b0;
          end else if (sample_valid) begin
            data_out        <= shreg;
            computed_parity <= exp_bit;
            parity_done     <= 1'b1;
            parity_error    <= err_c;
            // A simultaneous clear wins and the error is dropped
            if (err_c && !clear_count && (error_count != '1)) begin
              error_count <= error_count + ERR_CNT_WIDTH'(1);
            end
            state   <= IDLE;
            bit_cnt <= '0;
            acc     <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_parity_checker.sv
// Self-checking bench: three checker instances (8/8, 8/2, 7/8) share serial stimulus, each with its own enable.
module tb_uart_parity_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       sv;
  logic       sd;
  logic       clr;
  logic [2:0] mode;
  logic       en_a, en_b, en_c;

  logic [7:0] do_a;  logic cp_a, pd_a, pe_a;  logic [7:0] ec_a;
  logic [7:0] do_b;  logic cp_b, pd_b, pe_b;  logic [1:0] ec_b;
  logic [6:0] do_c;  logic cp_c, pd_c, pe_c;  logic [7:0] ec_c;

  int checks = 0;
  int errors = 0;

  int         ecnt[3];
  logic [8:0] mdata[3];
  logic       mcp[3];
  int         ecmax[3] = '{255, 3, 255};
  int         wid[3]   = '{8, 8, 7};

  always #5 clk = ~clk;

  uart_parity_checker #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(8)) dut_a (
    .clk_based_on_prescale(clk), .reset(rst), .parity_check_enable(en_a), .sample_valid(sv),
    .sampled_data(sd), .parity_mode(mode), .clear_count(clr), .data_out(do_a),
    .computed_parity(cp_a), .parity_done(pd_a), .parity_error(pe_a), .error_count(ec_a));

  uart_parity_checker #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(2)) dut_b (
    .clk_based_on_prescale(clk), .reset(rst), .parity_check_enable(en_b), .sample_valid(sv),
    .sampled_data(sd), .parity_mode(mode), .clear_count(clr), .data_out(do_b),
    .computed_parity(cp_b), .parity_done(pd_b), .parity_error(pe_b), .error_count(ec_b));

  uart_parity_checker #(.DATA_WIDTH(7), .ERR_CNT_WIDTH(8)) dut_c (
    .clk_based_on_prescale(clk), .reset(rst), .parity_check_enable(en_c), .sample_valid(sv),
    .sampled_data(sd), .parity_mode(mode), .clear_count(clr), .data_out(do_c),
    .computed_parity(cp_c), .parity_done(pd_c), .parity_error(pe_c), .error_count(ec_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: parity bit from counting ones in the data word
  function automatic logic model_par(input logic [2:0] m, input logic [8:0] d, input int n);
    int ones = 0;
    for (int k = 0; k < n; k++) ones += int'(d[k]);
    case (m)
      3'd1:    return (ones % 2) == 1;
      3'd2:    return (ones % 2) == 0;
      3'd3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic has_par(input logic [2:0] m);
    return (m >= 3'd1) && (m <= 3'd4);
  endfunction

  task automatic chk_inst(input string tag, input int i, input logic epd, input logic epe);
    logic [31:0] pd, pe, dout, cp, ec;
    case (i)
      0:       begin pd = 32'(pd_a); pe = 32'(pe_a); dout = 32'(do_a); cp = 32'(cp_a); ec = 32'(ec_a); end
      1:       begin pd = 32'(pd_b); pe = 32'(pe_b); dout = 32'(do_b); cp = 32'(cp_b); ec = 32'(ec_b); end
      default: begin pd = 32'(pd_c); pe = 32'(pe_c); dout = 32'(do_c); cp = 32'(cp_c); ec = 32'(ec_c); end
    endcase
    chk({tag, ".done"},  pd,   32'(epd));
    chk({tag, ".err"},   pe,   32'(epe));
    chk({tag, ".data"},  dout, 32'(mdata[i]));
    chk({tag, ".cpar"},  cp,   32'(mcp[i]));
    chk({tag, ".count"}, ec,   32'(ecnt[i]));
  endtask

  task automatic idle_chk(input string tag, input int i);
    @(negedge clk);
    chk_inst(tag, i, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    for (int j = 0; j < 3; j++) begin
      ecnt[j] = 0; mdata[j] = '0; mcp[j] = 1'b0;
    end
  endtask

  // Called at a negedge; returns at the negedge where parity_done should be high
  task automatic frame(input int i, input logic [8:0] d, input logic [2:0] m,
                       input logic pbit, input logic clr_par, input string tag);
    int         n = wid[i];
    logic       ep;
    logic       exp_pe;
    logic       use_clr;
    logic [8:0] mk;
    en_a = (i == 0); en_b = (i == 1); en_c = (i == 2);
    mode = m;
    for (int k = 0; k < n; k++) begin
      if (k > 0 && $urandom_range(3) == 0) begin
        sv = 1'b0; @(negedge clk);
      end
      sv = 1'b1; sd = d[k];
      @(negedge clk);
      if (k == 0) mode = 3'($urandom);
    end
    use_clr = has_par(m) && clr_par;
    if (has_par(m)) begin
      if ($urandom_range(3) == 0) begin
        sv = 1'b0; @(negedge clk);
      end
      sv = 1'b1; sd = pbit; clr = use_clr;
      @(negedge clk);
    end
    sv = 1'b0; clr = 1'b0;
    ep     = model_par(m, d, n);
    exp_pe = has_par(m) && (pbit != ep);
    mk     = 9'((1 << n) - 1);
    mdata[i] = d & mk;
    mcp[i]   = ep;
    if (use_clr) begin
      for (int j = 0; j < 3; j++) ecnt[j] = 0;
    end else if (exp_pe && ecnt[i] < ecmax[i]) begin
      ecnt[i]++;
    end
    chk_inst(tag, i, 1'b1, exp_pe);
  endtask

  initial begin
    int seq[5] = '{1, 2, 3, 3, 3};
    logic [8:0] d;
    rst = 1'b1; sv = 1'b0; sd = 1'b0; clr = 1'b0; mode = 3'd0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    model_reset();
    #1;
    chk_inst("reset_a", 0, 1'b0, 1'b0);
    chk_inst("reset_b", 1, 1'b0, 1'b0);
    chk_inst("reset_c", 2, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Even / odd / even-with-error on 8'hAA
    frame(0, 9'h0AA, 3'd1, 1'b0, 1'b0, "even_aa");
    chk("even_aa.data_lit", 32'(do_a), 32'h0AA);
    idle_chk("even_aa.after", 0);
    frame(0, 9'h0AA, 3'd2, 1'b1, 1'b0, "odd_aa");
    chk("odd_aa.cpar_lit", 32'(cp_a), 32'd1);
    idle_chk("odd_aa.after", 0);
    frame(0, 9'h0AA, 3'd1, 1'b1, 1'b0, "even_aa_bad");
    chk("even_aa_bad.count_lit", 32'(ec_a), 32'd1);
    idle_chk("even_aa_bad.after", 0);

    // None mode, then a frame starting in the pulse cycle
    frame(0, 9'h05C, 3'd0, 1'b0, 1'b0, "none_5c");
    d = 9'($urandom);
    frame(0, d, 3'd1, model_par(3'd1, d, 8), 1'b0, "b2b_even");
    idle_chk("b2b_even.after", 0);

    // Enable dropped after four bits of 8'hFF; sample while disabled is ignored
    en_a = 1'b1; en_b = 1'b0; en_c = 1'b0; mode = 3'd1;
    for (int k = 0; k < 4; k++) begin
      sv = 1'b1; sd = 1'b1; @(negedge clk);
    end
    en_a = 1'b0;
    @(negedge clk);
    chk_inst("abort", 0, 1'b0, 1'b0);
    sv = 1'b0;
    @(negedge clk);
    frame(0, 9'h003, 3'd1, 1'b0, 1'b0, "after_abort");
    idle_chk("after_abort.single", 0);

    // Two-bit saturating counter, then clear colliding with an error
    for (int k = 0; k < 5; k++) begin
      d = 9'($urandom);
      frame(1, d, 3'd1, ~model_par(3'd1, d, 8), 1'b0, "sat");
      chk("sat.seq", 32'(ec_b), 32'(seq[k]));
      idle_chk("sat.after", 1);
    end
    d = 9'($urandom);
    frame(1, d, 3'd1, ~model_par(3'd1, d, 8), 1'b1, "sat_clr");
    chk("sat_clr.count_lit", 32'(ec_b), 32'd0);
    idle_chk("sat_clr.after", 1);

    // Seven-bit mark/space
    frame(2, 9'h035, 3'd3, 1'b0, 1'b0, "mark7");
    chk("mark7.err_lit", 32'(pe_c), 32'd1);
    idle_chk("mark7.after", 2);
    frame(2, 9'h035, 3'd4, 1'b0, 1'b0, "space7");
    chk("space7.err_lit", 32'(pe_c), 32'd0);
    idle_chk("space7.after", 2);

    // Randomized frames across all instances and all mode encodings
    for (int r = 0; r < 60; r++) begin
      int          i;
      logic [2:0]  m;
      logic        pb;
      i  = int'($urandom_range(2));
      m  = 3'($urandom);
      d  = 9'($urandom);
      pb = ($urandom_range(1) == 0) ? model_par(m, d, wid[i]) : 1'($urandom);
      frame(i, d, m, pb, ($urandom_range(7) == 0), "rand");
      if ($urandom_range(1) == 0) idle_chk("rand.after", i);
    end
    idle_chk("rand.end", 0);

    // Asynchronous reset in the middle of a frame
    en_a = 1'b1; en_b = 1'b0; en_c = 1'b0; mode = 3'd1;
    for (int k = 0; k < 3; k++) begin
      sv = 1'b1; sd = 1'($urandom); @(negedge clk);
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk_inst("midreset", 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0; sv = 1'b0;
    @(negedge clk);
    chk_inst("midreset.nopulse", 0, 1'b0, 1'b0);
    d = 9'($urandom);
    frame(0, d, 3'd2, model_par(3'd2, d, 8), 1'b0, "post_reset");
    idle_chk("post_reset.after", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
